multicycle_controller: RTL

Control unit for the multicycle RV32I core. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback. Its outputs drive the datapath muxes, the PC and IR enables, the memory write strobe, and the register-file write enable (`RegWrite` → `WE3`). An `alu_decoder` sub-module turns `ALUOp`, `funct3`, `funct7b5` and `op[5]` into `ALUControl`.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// State encoding, opcodes, ALU/immediate selects and the immediate-type helper.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    JAL      = 4'd8,
    ALUWB    = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE: imm_src = IMM_S;
      OP_BEQ:   imm_src = IMM_B;
      OP_JAL:   imm_src = IMM_J;
      default:  imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from ALUOp and instruction fields.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // Only R-type (op5=1) can request sub; addi ignores IR[30].
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core: state register, next-state
// logic and per-state datapath control decode.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       Illegal
);

  state_t     state_q, state_d;
  logic       pc_update, branch, mem_write, ir_write, reg_write;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_update = 1'b0;
    branch    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    Illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_JAL:            state_d = JAL;
          OP_BEQ:            state_d = BEQ;
          default:           state_d = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        state_d   = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNC;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNC;
        state_d = ALUWB;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        Illegal = 1'b1;
        state_d = TRAP;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset gates the write strobes immediately so an abandoned instruction
  // cannot commit anything while rst_n is low.
  always_comb begin
    PCWrite  = rst_n & (pc_update | (branch & Zero));
    IRWrite  = rst_n & ir_write;
    MemWrite = rst_n & mem_write;
    RegWrite = rst_n & reg_write;
    ImmSrc   = imm_src(op);
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule
